bus_master_arb: RTL and testbench
=================================

// Module: bus_master_arb
// PURPOSE
//  Round-robin arbiter sharing one register bus between NUM_MASTERS requesters (CPU bridge,
//  JTAG debug, DMA sequencer). Grants one master at a time, drives the bus request fields,
//  waits for the bus ack (any number of bus_window_d-style pipeline stages), returns read
//  data/ack to the winner. A watchdog terminates transactions that are never acked.
// PARAMETERS
//  NUM_MASTERS  4     number of requesters, 2..8
//  ADDR_WIDTH   24    bus address width, equal to BUS_ADDR_WIDTH
//  DATA_WIDTH   32    bus data width, equal to BUS_DATA_WIDTH
//  TIMEOUT      255   cycles in WAIT without bus_ack before error termination, 2..65535
// PORTS
//  bus_clk      in   1              single clock for all logic
//  bus_reset    in   1              asynchronous, active-high reset
//  m_req        in   NUM_MASTERS    level request per master; held until its m_ack
//  m_rd_wr_l    in   NUM_MASTERS    1=read, 0=write, per master
//  m_addr       in   NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*AW +: AW]
//  m_wr_data    in   NUM_MASTERS*DATA_WIDTH  packed write data
//  m_ack        out  NUM_MASTERS    one-cycle completion pulse to the granted master
//  m_err        out  NUM_MASTERS    one-cycle pulse with m_ack when terminated by timeout
//  m_rd_data    out  DATA_WIDTH     shared read data, valid only in m_ack cycle
//  bus_req      out  1              one-cycle transaction strobe onto the bus
//  bus_rd_wr_l  out  1              direction, held stable from ISSUE through DONE
//  bus_addr     out  ADDR_WIDTH     address, held stable from ISSUE through DONE
//  bus_wr_data  out  DATA_WIDTH     write data, held stable from ISSUE through DONE
//  bus_ack      in   1              one-cycle completion pulse from the bus
//  bus_rd_data  in   DATA_WIDTH     read data, valid with bus_ack
//  busy         out  1              high in any state other than IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr pointer=0, timeout counter=0. All outputs registered.
//  - FSM IDLE->ISSUE->WAIT->DONE->IDLE.
//    IDLE: if any m_req, select winner = first requesting index at/after rr pointer (wrapping);
//      latch its rd_wr_l/addr/wr_data into bus regs and its index into grant; go ISSUE.
//    ISSUE: bus_req=1 for exactly this cycle; counter cleared; go WAIT.
//    WAIT: counter increments each cycle; on bus_ack capture bus_rd_data, err=0, go DONE;
//      else when counter==TIMEOUT-1 capture rd_data=0, err=1, go DONE.
//    DONE: m_ack[grant]=1 (and m_err[grant]=err) for one cycle; rr pointer=grant+1 mod
//      NUM_MASTERS; go IDLE.
//  - Latency: m_req sampled in IDLE at edge 0 -> bus_req high cycle 1; bus_ack in cycle k
//    -> m_ack high cycle k+1. Min turnaround 4 cycles/transaction; back-to-back allowed.
//  - bus_ack and timeout in same cycle: ack wins, err=0.
//  - bus_ack in IDLE/ISSUE/DONE (stray/late): ignored, no state change.
//  - Master dropping m_req mid-transaction: transaction still completes; ack still pulsed.
//  - m_req changes of non-granted masters never disturb the held bus fields.
//  - Fairness: a continuously requesting master waits at most NUM_MASTERS-1 transactions.
//  - Reset mid-transaction: immediate return to reset values; the bus transaction is
//    abandoned and any later bus_ack is ignored by IDLE.
//  - Counter width = clog2(TIMEOUT+1); never wraps (leaves WAIT first).
// STRUCTURE
//  - BUS_ADDR_WIDTH/BUS_DATA_WIDTH and the state encoding constants (IDLE=0,ISSUE=1,WAIT=2,
//    DONE=3) live in the shared bus_params.v include.
//  - One sub-module: rr_arbiter (combinational: req vector + pointer -> one-hot grant +
//    index + any). Top holds FSM, bus field registers, watchdog counter, response regs.
// TESTING
//  - Single read: m_req=4'b0010, addr 0x000100, bus_ack 3 cycles after bus_req with
//    rd_data 0xCAFEF00D -> one bus_req pulse, m_ack=4'b0010, m_rd_data=0xCAFEF00D, m_err=0.
//  - All four request continuously, ack after 1 cycle -> grant order 0,1,2,3,0; each
//    m_ack one cycle; bus_addr matches granted master for each transaction.
//  - No ack, TIMEOUT=8 -> m_ack+m_err to winner 8 cycles after WAIT entry, m_rd_data=0;
//    ack arriving 2 cycles later ignored, busy=0.
//  - bus_ack on exact timeout cycle -> m_err=0, data from bus_rd_data.
//  - Reset asserted in WAIT -> all outputs 0 same cycle; after release, stray bus_ack
//    ignored; next m_req=4'b1000 served first with pointer restarting at 0.
//  - Write from master 2 (wr_data 0x12345678) while master 0 toggles m_req ->
//    bus_wr_data/bus_addr/bus_rd_wr_l stay 0x12345678/master-2 values until DONE.

Source files
------------

// File: rtl/bus_master_arb_pkg.sv
// rtl/bus_master_arb_pkg.sv - shared widths, FSM encoding and helpers for the bus master arbiter
package bus_master_arb_pkg;

    localparam int BUS_ADDR_WIDTH = 24;
    localparam int BUS_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_master_arb_if.sv
// rtl/bus_master_arb_if.sv - requester and register-bus signal bundle for the arbiter
interface bus_master_arb_if
    import bus_master_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH  = BUS_DATA_WIDTH
) ();

    logic [NUM_MASTERS-1:0]            m_req;
    logic [NUM_MASTERS-1:0]            m_rd_wr_l;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data;
    logic [NUM_MASTERS-1:0]            m_ack;
    logic [NUM_MASTERS-1:0]            m_err;
    logic [DATA_WIDTH-1:0]             m_rd_data;
    logic                              bus_req;
    logic                              bus_rd_wr_l;
    logic [ADDR_WIDTH-1:0]             bus_addr;
    logic [DATA_WIDTH-1:0]             bus_wr_data;
    logic                              bus_ack;
    logic [DATA_WIDTH-1:0]             bus_rd_data;
    logic                              busy;

    modport master (
        input  m_req, m_rd_wr_l, m_addr, m_wr_data, bus_ack, bus_rd_data,
        output m_ack, m_err, m_rd_data, bus_req, bus_rd_wr_l, bus_addr, bus_wr_data, busy
    );

    modport slave (
        output m_req, m_rd_wr_l, m_addr, m_wr_data, bus_ack, bus_rd_data,
        input  m_ack, m_err, m_rd_data, bus_req, bus_rd_wr_l, bus_addr, bus_wr_data, busy
    );

endinterface

// File: rtl/bus_master_arb_rr_arbiter.sv
// rtl/bus_master_arb_rr_arbiter.sv - combinational round-robin pick: first requester at/after ptr
module bus_master_arb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       idx,
    output logic                   any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            // ptr is always < NUM_MASTERS, so one subtraction wraps the scan
            j = int'(ptr) + i;
            if (j >= NUM_MASTERS) begin
                j = j - NUM_MASTERS;
            end
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_master_arb.sv
// rtl/bus_master_arb.sv - round-robin register-bus arbiter with ack watchdog
module bus_master_arb
    import bus_master_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int TIMEOUT     = 255
) (
    input  logic             bus_clk,
    input  logic             bus_reset,
    bus_master_arb_if.master bif
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        arb_idx;
    logic [NUM_MASTERS-1:0]  arb_grant;
    logic [NUM_MASTERS-1:0]  grant_oh;
    logic                    arb_any;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    timeout_hit;

    logic                    take_req;
    logic                    acked;
    logic                    finish;
    logic                    bus_req_d;
    logic                    busy_d;
    logic [NUM_MASTERS-1:0]  m_ack_d;
    logic [NUM_MASTERS-1:0]  m_err_d;
    logic [DATA_WIDTH-1:0]   m_rd_data_d;

    bus_master_arb_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr (
        .req   (bif.m_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (arb_any) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  if (bif.bus_ack || timeout_hit) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; an ack on the timeout cycle wins
    always_comb begin
        take_req    = (state == ST_IDLE) && arb_any;
        acked       = (state == ST_WAIT) && bif.bus_ack;
        finish      = (state == ST_WAIT) && (bif.bus_ack || timeout_hit);
        bus_req_d   = take_req;
        busy_d      = (next_state != ST_IDLE);
        m_ack_d     = finish ? grant_oh : '0;
        m_err_d     = (finish && !acked) ? grant_oh : '0;
        m_rd_data_d = acked ? bif.bus_rd_data : '0;
    end

    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            grant_idx       <= '0;
            grant_oh        <= '0;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            bif.bus_rd_wr_l <= 1'b0;
            bif.bus_addr    <= '0;
            bif.bus_wr_data <= '0;
        end else begin
            // Bus fields are captured only here, so later m_req churn cannot disturb them
            if (take_req) begin
                grant_idx       <= arb_idx;
                grant_oh        <= arb_grant;
                bif.bus_rd_wr_l <= bif.m_rd_wr_l[arb_idx];
                bif.bus_addr    <= bif.m_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                bif.bus_wr_data <= bif.m_wr_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state == ST_DONE) begin
                rr_ptr <= IDX_W'(wrap_inc(int'(grant_idx), NUM_MASTERS));
            end
        end
    end

    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            bif.bus_req   <= 1'b0;
            bif.busy      <= 1'b0;
            bif.m_ack     <= '0;
            bif.m_err     <= '0;
            bif.m_rd_data <= '0;
        end else begin
            bif.bus_req   <= bus_req_d;
            bif.busy      <= busy_d;
            bif.m_ack     <= m_ack_d;
            bif.m_err     <= m_err_d;
            bif.m_rd_data <= m_rd_data_d;
        end
    end

endmodule

// File: tb/tb_bus_master_arb.sv
// tb/tb_bus_master_arb.sv - vector table plus scoreboard bench for bus_master_arb (TIMEOUT=8)
module tb_bus_master_arb;

    localparam int NM = 4;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        int          mst;
        logic        rw;
        logic [23:0] addr;
        logic [31:0] wd;
        int          d;
        logic [31:0] brd;
        bit          tog;
        logic [3:0]  e_oh;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [3:0]  oh;
        logic        err;
        logic [31:0] rd;
        int          lat;
        logic        rw;
        logic [23:0] addr;
        logic [31:0] wd;
    } exp_t;

    logic bus_clk;
    logic bus_reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    exp_t held;
    exp_t cur;
    int   req_cyc = 0;
    bit   in_txn  = 0;
    vec_t vecs[6];

    bus_master_arb_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    bus_master_arb #(
        .NUM_MASTERS (NM),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT     (TO)
    ) dut (
        .bus_clk   (bus_clk),
        .bus_reset (bus_reset),
        .bif       (bif)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;
    always @(posedge bus_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic fail_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no/extra event want expected event", name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {bif.busy, bif.bus_req, bif.m_ack, bif.m_err, bif.bus_rd_wr_l}, 64'd0);
        check({name, "_rd"}, bif.m_rd_data, 64'd0);
        check({name, "_addr"}, bif.bus_addr, 64'd0);
        check({name, "_wd"}, bif.bus_wr_data, 64'd0);
    endtask

    always @(negedge bus_clk) begin
        if (bus_reset) begin
            in_txn = 0;
        end else begin
            if (bif.bus_req) begin
                if (exp_q.size() == 0) begin
                    fail_evt("unexpected_bus_req");
                end else begin
                    held = exp_q[0];
                    check("bus_fields", {bif.bus_rd_wr_l, bif.bus_addr, bif.bus_wr_data},
                          {held.rw, held.addr, held.wd});
                    req_cyc = cyc;
                    in_txn  = 1;
                end
            end else if (in_txn) begin
                check("bus_hold", {bif.busy, bif.bus_rd_wr_l, bif.bus_addr, bif.bus_wr_data},
                      {1'b1, held.rw, held.addr, held.wd});
            end
            if (|bif.m_ack) begin
                if (exp_q.size() == 0) begin
                    fail_evt("unexpected_m_ack");
                end else begin
                    cur = exp_q.pop_front();
                    check("m_ack", bif.m_ack, cur.oh);
                    check("m_err", bif.m_err, cur.err ? cur.oh : 4'b0);
                    check("m_rd_data", bif.m_rd_data, cur.rd);
                    check("latency", cyc - req_cyc, cur.lat);
                    in_txn = 0;
                end
            end
        end
    end

    task automatic wait_bus_req(output bit ok);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge bus_clk);
            if (bif.bus_req) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_evt("bus_req_wait");
    endtask

    task automatic wait_m_ack(output logic [3:0] seen);
        seen = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge bus_clk);
            if (|bif.m_ack) begin
                seen = bif.m_ack;
                break;
            end
        end
        if (seen == 4'b0) fail_evt("m_ack_wait");
    endtask

    task automatic set_master(input int m, input logic rw, input logic [23:0] a, input logic [31:0] wd);
        bif.m_rd_wr_l[m]       = rw;
        bif.m_addr[m*AW +: AW] = a;
        bif.m_wr_data[m*DW +: DW] = wd;
    endtask

    task automatic push_exp(input logic [3:0] oh, input logic err, input logic [31:0] rd, input int lat,
                            input logic rw, input logic [23:0] a, input logic [31:0] wd);
        exp_t e;
        e.oh = oh; e.err = err; e.rd = rd; e.lat = lat; e.rw = rw; e.addr = a; e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic do_txn(input vec_t v);
        @(posedge bus_clk); #1;
        set_master(v.mst, v.rw, v.addr, v.wd);
        bif.m_req[v.mst] = 1'b1;
        push_exp(v.e_oh, v.e_err, v.e_rd, v.e_lat, v.rw, v.addr, v.wd);
        fork
            begin
                bit ok;
                wait_bus_req(ok);
                if (ok) begin
                    repeat (v.d) @(posedge bus_clk);
                    #1 bif.bus_ack = 1'b1; bif.bus_rd_data = v.brd;
                    @(posedge bus_clk);
                    #1 bif.bus_ack = 1'b0; bif.bus_rd_data = '0;
                end
            end
            begin
                logic [3:0] seen;
                wait_m_ack(seen);
                @(posedge bus_clk);
                #1 bif.m_req[v.mst] = 1'b0;
            end
            begin
                bit ok2;
                if (v.tog) begin
                    wait_bus_req(ok2);
                    for (int k = 0; k < 4; k++) begin
                        @(posedge bus_clk);
                        #1 bif.m_req[0] = ~bif.m_req[0];
                        bif.m_rd_wr_l[0] = ~bif.m_rd_wr_l[0];
                        bif.m_addr[0 +: AW] = AW'($urandom);
                        bif.m_wr_data[0 +: DW] = $urandom;
                    end
                    bif.m_req[0] = 1'b0;
                end
            end
        join
        @(negedge bus_clk);
        check("idle_after_txn", bif.busy, 1'b0);
    endtask

    task automatic multi_run(input logic [3:0] mask, input int n, input bit keep, input logic [31:0] base);
        bit ok;
        logic [3:0] seen;
        @(posedge bus_clk); #1 bif.m_req = mask;
        for (int t = 0; t < n; t++) begin
            wait_bus_req(ok);
            if (!ok) break;
            @(posedge bus_clk);
            #1 bif.bus_ack = 1'b1; bif.bus_rd_data = base + 32'(t);
            @(posedge bus_clk);
            #1 bif.bus_ack = 1'b0; bif.bus_rd_data = '0;
            @(negedge bus_clk);
            seen = bif.m_ack;
            if (!keep) begin
                @(posedge bus_clk);
                #1 bif.m_req = bif.m_req & ~seen;
            end
        end
        @(posedge bus_clk); #1 bif.m_req = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int order[5];
        bit ok;
        order = '{0, 1, 2, 3, 0};
        bus_reset = 1'b1;
        bif.m_req = '0; bif.m_rd_wr_l = '0; bif.m_addr = '0; bif.m_wr_data = '0;
        bif.bus_ack = 1'b0; bif.bus_rd_data = '0;

        vecs[0] = '{1, 1'b1, 24'h000100, 32'h0,        3,  32'hCAFEF00D, 1'b0, 4'b0010, 1'b0, 32'hCAFEF00D, 4};
        vecs[1] = '{0, 1'b0, 24'h00ABCD, 32'hDEADBEEF, 1,  32'h55555555, 1'b0, 4'b0001, 1'b0, 32'h55555555, 2};
        vecs[2] = '{3, 1'b1, 24'hFFFFFF, 32'h0,        8,  32'h0BADC0DE, 1'b0, 4'b1000, 1'b0, 32'h0BADC0DE, 9};
        vecs[3] = '{2, 1'b1, 24'h123456, 32'h0,        11, 32'h99999999, 1'b0, 4'b0100, 1'b1, 32'h0,        9};
        vecs[4] = '{0, 1'b1, 24'h000040, 32'h0,        9,  32'h88888888, 1'b0, 4'b0001, 1'b1, 32'h0,        9};
        vecs[5] = '{2, 1'b0, 24'h000200, 32'h12345678, 6,  32'h77777777, 1'b1, 4'b0100, 1'b0, 32'h77777777, 7};

        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        check_all_zero("reset");
        @(posedge bus_clk); #1 bus_reset = 1'b0;

        for (int m = 0; m < NM; m++) set_master(m, 1'b1, 24'h0A0000 + 24'(m), 32'h11110000 + 32'(m));
        for (int t = 0; t < 5; t++) begin
            push_exp(4'b0001 << order[t], 1'b0, 32'hA0000000 + 32'(t), 2,
                     1'b1, 24'h0A0000 + 24'(order[t]), 32'h11110000 + 32'(order[t]));
        end
        multi_run(4'b1111, 5, 1'b1, 32'hA0000000);
        @(negedge bus_clk);
        check("rr_idle", bif.busy, 1'b0);
        check("rr_queue_drained", exp_q.size(), 0);

        for (int v = 0; v < 6; v++) do_txn(vecs[v]);

        @(posedge bus_clk); #1;
        set_master(1, 1'b1, 24'h00BEEF, 32'h0);
        bif.m_req = 4'b0010;
        push_exp(4'b0010, 1'b0, 32'h0, 0, 1'b1, 24'h00BEEF, 32'h0);
        wait_bus_req(ok);
        @(posedge bus_clk); #1;
        @(posedge bus_clk); #1;
        check("pre_reset_busy", bif.busy, 1'b1);
        bus_reset = 1'b1;
        bif.m_req = '0;
        #1 check_all_zero("reset_in_wait");
        exp_q.delete();
        @(posedge bus_clk); #1 bus_reset = 1'b0;
        @(posedge bus_clk); #1 bif.bus_ack = 1'b1; bif.bus_rd_data = 32'hFFFFFFFF;
        @(posedge bus_clk); #1 bif.bus_ack = 1'b0; bif.bus_rd_data = '0;
        @(negedge bus_clk);
        check("stray_ack_busy", bif.busy, 1'b0);
        check("stray_ack_m_ack", bif.m_ack, 4'b0);

        set_master(0, 1'b1, 24'h000010, 32'h0);
        set_master(3, 1'b0, 24'h000030, 32'hABCD0003);
        push_exp(4'b0001, 1'b0, 32'hB0000000, 2, 1'b1, 24'h000010, 32'h0);
        push_exp(4'b1000, 1'b0, 32'hB0000001, 2, 1'b0, 24'h000030, 32'hABCD0003);
        multi_run(4'b1001, 2, 1'b0, 32'hB0000000);
        @(negedge bus_clk);
        check("final_idle", bif.busy, 1'b0);
        check("final_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
